// File: rtl/fsm_step_scheduler_if.sv
// rtl/fsm_step_scheduler_if.sv - requester/datapath signal bundle for fsm_step_scheduler
// Purpose: groups both requester handshakes and the scheduler's datapath/status outputs.
// Signals:
//   req0/cnt0/dir0, req1/cnt1/dir1 : requester request, step count, direction (1 = up)
//   step_en, dir                   : datapath step enable and direction (input A)
//   busy, owner                    : scheduler status, current/last granted requester
//   done0, done1, aborted          : completion pulses, aborted qualifies a done pulse
//   pos                            : shadow 3-bit datapath position
// Modports: master = requester side, slave = scheduler side.
interface fsm_step_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             req0;
    logic [CNT_W-1:0] cnt0;
    logic             dir0;
    logic             req1;
    logic [CNT_W-1:0] cnt1;
    logic             dir1;
    logic             step_en;
    logic             dir;
    logic             busy;
    logic             owner;
    logic             done0;
    logic             done1;
    logic             aborted;
    logic [2:0]       pos;

    modport master (
        output req0, cnt0, dir0, req1, cnt1, dir1,
        input  step_en, dir, busy, owner, done0, done1, aborted, pos
    );

    modport slave (
        input  req0, cnt0, dir0, req1, cnt1, dir1,
        output step_en, dir, busy, owner, done0, done1, aborted, pos
    );
endinterface

// File: rtl/fsm_step_scheduler.sv
// rtl/fsm_step_scheduler.sv - round-robin scheduler sharing a 3-bit stepping datapath
// Purpose: grants one of two requesters, issues exactly N step enables in the
//   requested direction, then pulses that requester's done (with aborted if it
//   withdrew its request early). A shadow position mirrors the datapath state.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fsm_step_scheduler_if slave modport (requests in, datapath/status out)
// Every output is a register; no input reaches an output combinationally.
module fsm_step_scheduler #(
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fsm_step_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             last_owner;

    logic             grant_valid;
    logic             grant_sel;
    logic [CNT_W-1:0] grant_cnt;
    logic             grant_dir;
    logic             owner_req;

    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        // On a tie the requester that did not win last time gets the grant.
        grant_sel   = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
        grant_cnt   = grant_sel ? bus.cnt1 : bus.cnt0;
        grant_dir   = grant_sel ? bus.dir1 : bus.dir0;
        owner_req   = bus.owner ? bus.req1 : bus.req0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= '0;
            last_owner  <= 1'b1;
            bus.step_en <= 1'b0;
            bus.dir     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.owner   <= 1'b0;
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.aborted <= 1'b0;
            bus.pos     <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done0   <= 1'b0;
                    bus.done1   <= 1'b0;
                    bus.aborted <= 1'b0;
                    if (grant_valid) begin
                        bus.owner  <= grant_sel;
                        last_owner <= grant_sel;
                        remaining  <= grant_cnt;
                        bus.dir    <= grant_dir;
                        bus.busy   <= 1'b1;
                        if (grant_cnt != '0) begin
                            state       <= STEP;
                            bus.step_en <= 1'b1;
                        end else begin
                            // Zero-length request completes without any step.
                            state     <= DONE;
                            bus.done0 <= ~grant_sel;
                            bus.done1 <= grant_sel;
                        end
                    end
                end

                STEP: begin
                    // step_en was high this cycle, so this step always counts,
                    // including the cycle in which the owner dropped its request.
                    remaining <= remaining - CNT_W'(1);
                    bus.pos   <= bus.dir ? bus.pos + 3'd1 : bus.pos - 3'd1;
                    if (remaining == CNT_W'(1) || !owner_req) begin
                        state       <= DONE;
                        bus.step_en <= 1'b0;
                        bus.done0   <= ~bus.owner;
                        bus.done1   <= bus.owner;
                        // Withdrawal on the final step still delivered all N steps.
                        bus.aborted <= (remaining != CNT_W'(1));
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.done0   <= 1'b0;
                    bus.done1   <= 1'b0;
                    bus.aborted <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    bus.step_en <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.done0   <= 1'b0;
                    bus.done1   <= 1'b0;
                    bus.aborted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_step_scheduler.sv
// tb/tb_fsm_step_scheduler.sv - self-checking bench for fsm_step_scheduler
module tb_fsm_step_scheduler;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fsm_step_scheduler_if #(.CNT_W(CNT_W)) bus ();

    fsm_step_scheduler #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       who;
        logic       ab;
        int         steps;
        logic [2:0] pos;
        logic       dir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_count = 0;
    int   done_seen = 0;

    // Completion monitor: counts issued steps and scores each done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            step_count = 0;
        end else begin
            if (bus.step_en === 1'b1) step_count = step_count + 1;
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
                n_cmp = n_cmp + 1;
                if (sb.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_done: done1/done0=%b%b, required no done", bus.done1, bus.done0);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.done1, bus.done0} !== (mon_e.who ? 2'b10 : 2'b01)) begin
                        n_bad = n_bad + 1;
                        $display("FAIL done_which: done1/done0=%b%b, required owner %0d", bus.done1, bus.done0, mon_e.who);
                    end
                    n_cmp = n_cmp + 1;
                    if (bus.aborted !== mon_e.ab) begin
                        n_bad = n_bad + 1;
                        $display("FAIL done_aborted: got %b, required %b", bus.aborted, mon_e.ab);
                    end
                    n_cmp = n_cmp + 1;
                    if (step_count != mon_e.steps) begin
                        n_bad = n_bad + 1;
                        $display("FAIL step_count: got %0d, required %0d", step_count, mon_e.steps);
                    end
                    n_cmp = n_cmp + 1;
                    if (bus.pos !== mon_e.pos) begin
                        n_bad = n_bad + 1;
                        $display("FAIL done_pos: got %0d, required %0d", bus.pos, mon_e.pos);
                    end
                    n_cmp = n_cmp + 1;
                    if (bus.owner !== mon_e.who || bus.dir !== mon_e.dir) begin
                        n_bad = n_bad + 1;
                        $display("FAIL done_owner_dir: owner=%b dir=%b, required owner=%b dir=%b", bus.owner, bus.dir, mon_e.who, mon_e.dir);
                    end
                    n_cmp = n_cmp + 1;
                    if (bus.step_en !== 1'b0 || bus.busy !== 1'b1) begin
                        n_bad = n_bad + 1;
                        $display("FAIL done_flags: step_en=%b busy=%b, required 0 1", bus.step_en, bus.busy);
                    end
                end
                step_count = 0;
                done_seen  = done_seen + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic who, input logic ab, input int steps, input logic [2:0] pos, input logic dir);
        exp_t e;
        e.who = who; e.ab = ab; e.steps = steps; e.pos = pos; e.dir = dir;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_seen <= base && n < 100) begin
            tick();
            n++;
        end
        n_cmp = n_cmp + 1;
        if (done_seen <= base) begin
            n_bad = n_bad + 1;
            $display("FAIL done_timeout: done count %0d, required more than %0d", done_seen, base);
        end
    endtask

    task automatic test_reset();
        bus.req0 = 1'b0; bus.cnt0 = '0; bus.dir0 = 1'b0;
        bus.req1 = 1'b0; bus.cnt1 = '0; bus.dir1 = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        n_cmp = n_cmp + 1;
        if ({bus.step_en, bus.dir, bus.busy, bus.owner, bus.done0, bus.done1, bus.aborted, bus.pos} !== 10'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_outputs: step_en=%b dir=%b busy=%b owner=%b done=%b%b aborted=%b pos=%0d, required all 0",
                     bus.step_en, bus.dir, bus.busy, bus.owner, bus.done1, bus.done0, bus.aborted, bus.pos);
        end
        reset = 1'b1;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0 || bus.step_en !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_idle: busy=%b step_en=%b, required 0 0", bus.busy, bus.step_en);
        end
    endtask

    task automatic test_single_up();
        int base = done_seen;
        push(1'b0, 1'b0, 3, 3'd3, 1'b1);
        bus.req0 = 1'b1; bus.cnt0 = 4'd3; bus.dir0 = 1'b1;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.step_en !== 1'b1 || bus.busy !== 1'b1 || bus.dir !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL single_first_step: step_en=%b busy=%b dir=%b, required 1 1 1", bus.step_en, bus.busy, bus.dir);
        end
        wait_done(base);
        bus.req0 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.step_en !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL single_after: busy=%b done0=%b step_en=%b, required 0 0 0", bus.busy, bus.done0, bus.step_en);
        end
    endtask

    task automatic test_arbitration();
        int base;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        base = done_seen;
        push(1'b0, 1'b0, 2, 3'd2, 1'b1);
        bus.req0 = 1'b1; bus.cnt0 = 4'd2; bus.dir0 = 1'b1;
        bus.req1 = 1'b1; bus.cnt1 = 4'd2; bus.dir1 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.owner !== 1'b0 || bus.dir !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL arb_first: owner=%b dir=%b, required 0 1", bus.owner, bus.dir);
        end
        wait_done(base);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        base = done_seen;
        push(1'b1, 1'b0, 2, 3'd0, 1'b0);
        push(1'b0, 1'b0, 2, 3'd2, 1'b1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.owner !== 1'b1 || bus.dir !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL arb_alternate: owner=%b dir=%b, required 1 0", bus.owner, bus.dir);
        end
        wait_done(base);
        bus.req1 = 1'b0;
        wait_done(base + 1);
        bus.req0 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL arb_idle: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_zero_count();
        int base = done_seen;
        push(1'b1, 1'b0, 0, 3'd2, 1'b1);
        bus.req1 = 1'b1; bus.cnt1 = 4'd0; bus.dir1 = 1'b1;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.done1 !== 1'b1 || bus.step_en !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL zero_done: done1=%b step_en=%b busy=%b, required 1 0 1", bus.done1, bus.step_en, bus.busy);
        end
        bus.req1 = 1'b0;
        wait_done(base);
        tick();
        n_cmp = n_cmp + 1;
        if (bus.done1 !== 1'b0 || bus.busy !== 1'b0 || bus.pos !== 3'd2) begin
            n_bad = n_bad + 1;
            $display("FAIL zero_after: done1=%b busy=%b pos=%0d, required 0 0 2", bus.done1, bus.busy, bus.pos);
        end
    endtask

    task automatic test_wrap();
        int base = done_seen;
        logic [2:0] exp_pos [4];
        exp_pos[0] = 3'd1; exp_pos[1] = 3'd0; exp_pos[2] = 3'd7; exp_pos[3] = 3'd6;
        push(1'b0, 1'b0, 1, 3'd1, 1'b0);
        bus.req0 = 1'b1; bus.cnt0 = 4'd1; bus.dir0 = 1'b0;
        wait_done(base);
        bus.req0 = 1'b0;
        tick();
        base = done_seen;
        push(1'b0, 1'b0, 3, 3'd6, 1'b0);
        bus.req0 = 1'b1; bus.cnt0 = 4'd3; bus.dir0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp = n_cmp + 1;
            if (bus.pos !== exp_pos[i]) begin
                n_bad = n_bad + 1;
                $display("FAIL wrap_pos[%0d]: got %0d, required %0d", i, bus.pos, exp_pos[i]);
            end
        end
        bus.req0 = 1'b0;
        wait_done(base);
        tick();
    endtask

    task automatic test_abort();
        int base = done_seen;
        push(1'b0, 1'b1, 4, 3'd2, 1'b1);
        bus.req0 = 1'b1; bus.cnt0 = 4'd10; bus.dir0 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        n_cmp = n_cmp + 1;
        if (bus.step_en !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL abort_step4: step_en=%b, required 1", bus.step_en);
        end
        bus.req0 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.done0 !== 1'b1 || bus.aborted !== 1'b1 || bus.step_en !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL abort_done: done0=%b aborted=%b step_en=%b, required 1 1 0", bus.done0, bus.aborted, bus.step_en);
        end
        wait_done(base);
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.aborted !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL abort_idle: busy=%b done0=%b aborted=%b, required 0 0 0", bus.busy, bus.done0, bus.aborted);
        end
    endtask

    task automatic test_max_count();
        int base = done_seen;
        push(1'b1, 1'b0, 15, 3'd1, 1'b1);
        bus.req1 = 1'b1; bus.cnt1 = 4'd15; bus.dir1 = 1'b1;
        tick();
        wait_done(base);
        bus.req1 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0 || bus.step_en !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL max_idle: busy=%b step_en=%b, required 0 0", bus.busy, bus.step_en);
        end
    endtask

    task automatic test_reset_mid_step();
        int base;
        bus.req0 = 1'b1; bus.cnt0 = 4'd8; bus.dir0 = 1'b1;
        tick();
        tick();
        tick();
        n_cmp = n_cmp + 1;
        if (bus.pos !== 3'd3 || bus.step_en !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL midstep_pre: pos=%0d step_en=%b, required 3 1", bus.pos, bus.step_en);
        end
        reset = 1'b0;
        bus.req0 = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if (bus.step_en !== 1'b0 || bus.busy !== 1'b0 || bus.pos !== 3'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL midstep_reset: step_en=%b busy=%b pos=%0d, required 0 0 0", bus.step_en, bus.busy, bus.pos);
        end
        tick();
        reset = 1'b1;
        tick();
        base = done_seen;
        push(1'b0, 1'b0, 1, 3'd1, 1'b1);
        push(1'b1, 1'b0, 1, 3'd0, 1'b0);
        bus.req0 = 1'b1; bus.cnt0 = 4'd1; bus.dir0 = 1'b1;
        bus.req1 = 1'b1; bus.cnt1 = 4'd1; bus.dir1 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.owner !== 1'b0 || bus.step_en !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL post_reset_grant: owner=%b step_en=%b, required 0 1", bus.owner, bus.step_en);
        end
        wait_done(base);
        bus.req0 = 1'b0;
        wait_done(base + 1);
        bus.req1 = 1'b0;
        tick();
        n_cmp = n_cmp + 1;
        if (bus.busy !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL post_reset_idle: busy=%b, required 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_arbitration();
        test_zero_count();
        test_wrap();
        test_abort();
        test_max_count();
        test_reset_mid_step();
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
